otter_fetch_stage: RTL and testbench
====================================

// Module: otter_fetch_stage
// PURPOSE
//  IF stage of the pipelined OTTER. Owns the PC and drives the instruction
//  port of the OTTER memory: MEM_ADDR1 = PC[15:2], MEM_RDEN1, 1-cycle
//  synchronous MEM_DOUT1. Delivers {PC, PC+4, INSTR, VALID} to decode.
//  Also handles hazard-unit stalls, taken-branch redirects, misaligned targets,
//  out-of-range fetches, and a fetched-instruction counter.
// PARAMETERS
//  RESET_VEC   32'h0000_0000  PC value loaded on reset (word aligned)
//  IMEM_WORDS  4096           valid instruction words; fetch at PC[31:2] >= this faults
// PORTS
//  CLK          in   1   single clock, all state on posedge
//  RST          in   1   asynchronous, active-high reset
//  STALL        in   1   hazard unit: hold PC and the delivered instruction
//  BR_TAKEN     in   1   redirect PC to BR_TARGET this cycle
//  BR_TARGET    in   32  redirect address (byte)
//  MEM_DOUT1    in   32  instruction word from memory, valid 1 cycle after address
//  MEM_RDEN1    out  1   instruction read enable (= !STALL)
//  MEM_ADDR1    out  14  word address = pc_q[15:2] (combinational from pc_q)
//  IF_PC        out  32  byte PC of IF_INSTR
//  IF_PC4       out  32  IF_PC + 4, 32-bit wrap
//  IF_INSTR     out  32  = MEM_DOUT1 when IF_VALID, else 32'h0000_0013 (NOP)
//  IF_VALID     out  1   IF_INSTR is a real, on-path instruction
//  IF_FAULT     out  1   IF_PC was out of range (IF_VALID also 1; decode traps)
//  MISALIGN     out  1   sticky: some accepted BR_TARGET had [1:0] != 0
//  FETCH_CNT    out  32  count of instructions handed to decode
// BEHAVIOUR
//  State: pc_q (address being read), pcd_q (PC of the word on MEM_DOUT1),
//   vld_q, flt_q, mis_q, cnt_q.
//  Reset (async): pc_q=RESET_VEC, pcd_q=RESET_VEC, vld_q=0, flt_q=0,
//   mis_q=0, cnt_q=0. Outputs after reset: IF_VALID=0, IF_INSTR=NOP,
//   IF_PC=RESET_VEC, MISALIGN=0, FETCH_CNT=0, MEM_RDEN1=1 once RST deasserts.
//  Latency: address in cycle N -> IF_INSTR valid in cycle N+1. First valid
//   instruction is available 1 cycle after RST falls.
//  Normal (!STALL, !BR_TAKEN): pc_q<=pc_q+4; pcd_q<=pc_q; vld_q<=1;
//   flt_q<=(pc_q[31:2]>=IMEM_WORDS).
//  STALL && !BR_TAKEN: MEM_RDEN1=0, so memory holds MEM_DOUT1. pc_q, pcd_q,
//   vld_q, and flt_q hold. Outputs are stable for as many stall cycles as asserted.
//  BR_TAKEN (priority over STALL): pc_q<={BR_TARGET[31:2],2'b00}; vld_q<=0,
//   so the wrong-path word becomes a bubble next cycle. pcd_q<=pc_q.
//   If BR_TARGET[1:0]!=0, mis_q<=1 (sticky until RST).
//   With STALL also high, MEM_RDEN1 stays 0. The bubble persists, and the target
//   is read on the first unstalled cycle.
//  Back-to-back BR_TAKEN: each redirect overrides the previous one. Only the
//   last target is fetched, with one bubble after the last.
//  FETCH_CNT: +1 on every cycle with IF_VALID && !STALL && !BR_TAKEN.
//   Wraps 2^32-1 -> 0 with no flag.
//  PC arithmetic: 32-bit unsigned, wraps at 32'hFFFF_FFFC -> 0. MEM_ADDR1 always
//   comes from pc_q[15:2] even when out of range; IF_FAULT flags it.
//  RST asserted mid-stall or mid-redirect: all state returns to reset values
//   immediately. The in-flight memory word is discarded (vld_q=0).
// STRUCTURE
//  otter_pkg: XLEN=32, RESET_VEC default, NOP_INSTR=32'h0000_0013, IMEM_WORDS.
//  Single module, no sub-module: PC register, next-PC mux, one delay stage
//   matching the memory read latency, and the counter.
// TESTING (bench models memory: sync read, hold on RDEN1=0)
//  1 Reset release, RESET_VEC=0 -> cycle 1: IF_PC=0, IF_VALID=1. Then IF_PC
//    0,4,8,C on consecutive cycles, and IF_PC4 = IF_PC + 4.
//  2 STALL high for 3 cycles while IF_PC=8 -> IF_PC=8 and IF_INSTR held for all
//    3 cycles, MEM_RDEN1=0, FETCH_CNT frozen. Cycle after release: IF_PC=C.
//  3 BR_TAKEN, BR_TARGET=0x100 while IF_PC=C -> next cycle IF_VALID=0 (NOP),
//    then IF_PC=0x100 valid, then 0x104.
//  4 BR_TAKEN and STALL together, BR_TARGET=0x40 -> MEM_RDEN1=0 and IF_VALID=0
//    while stalled. First unstalled cycle reads 0x40, so IF_PC=0x40 valid next.
//  5 BR_TARGET=0x202 -> MISALIGN=1 and stays 1, fetch goes to 0x200. RST clears
//    MISALIGN.
//  6 Redirect to 0x4000 (word 4096) -> IF_FAULT=1, IF_VALID=1. Async RST pulse
//    mid-sequence -> same cycle: IF_VALID=0, FETCH_CNT=0, IF_PC=RESET_VEC.

Source files
------------

// File: rtl/otter_pkg.sv
// otter_pkg: shared widths, reset vector, NOP encoding and instruction memory size
package otter_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_VEC = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
  localparam int IMEM_WORDS = 4096;
endpackage

// File: rtl/otter_fetch_stage.sv
// otter_fetch_stage: OTTER IF stage; owns the PC, drives the sync instruction port, delivers PC/PC+4/instr/valid/fault to decode with stall, redirect, misalign and fetch-count handling
module otter_fetch_stage
  import otter_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC  = otter_pkg::RESET_VEC,
  parameter int              IMEM_WORDS = otter_pkg::IMEM_WORDS
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            STALL,
  input  logic            BR_TAKEN,
  input  logic [XLEN-1:0] BR_TARGET,
  input  logic [XLEN-1:0] MEM_DOUT1,
  output logic            MEM_RDEN1,
  output logic [13:0]     MEM_ADDR1,
  output logic [XLEN-1:0] IF_PC,
  output logic [XLEN-1:0] IF_PC4,
  output logic [XLEN-1:0] IF_INSTR,
  output logic            IF_VALID,
  output logic            IF_FAULT,
  output logic            MISALIGN,
  output logic [XLEN-1:0] FETCH_CNT
);
  logic [XLEN-1:0] pc_q, pc_d, pcd_q, pcd_d, cnt_q, cnt_d;
  logic vld_q, vld_d, flt_q, flt_d, mis_q, mis_d, oor;
  assign oor = pc_q[31:2] >= 30'(IMEM_WORDS);
  always_comb begin
    pc_d  = BR_TAKEN ? {BR_TARGET[31:2], 2'b00} : STALL ? pc_q : pc_q + 32'd4;
    pcd_d = BR_TAKEN ? pc_q : STALL ? pcd_q : pc_q;
    vld_d = BR_TAKEN ? 1'b0 : STALL ? vld_q : 1'b1;
    flt_d = BR_TAKEN ? 1'b0 : STALL ? flt_q : oor;
    mis_d = mis_q | (BR_TAKEN & (|BR_TARGET[1:0]));
    cnt_d = cnt_q + {31'd0, vld_q & ~STALL & ~BR_TAKEN};
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      pc_q  <= RESET_VEC;
      pcd_q <= RESET_VEC;
      vld_q <= 1'b0;
      flt_q <= 1'b0;
      mis_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      pcd_q <= pcd_d;
      vld_q <= vld_d;
      flt_q <= flt_d;
      mis_q <= mis_d;
      cnt_q <= cnt_d;
    end
  assign MEM_RDEN1 = ~STALL;
  assign MEM_ADDR1 = pc_q[15:2];
  assign IF_PC     = pcd_q;
  assign IF_PC4    = pcd_q + 32'd4;
  assign IF_INSTR  = vld_q ? MEM_DOUT1 : NOP_INSTR;
  assign IF_VALID  = vld_q;
  assign IF_FAULT  = flt_q;
  assign MISALIGN  = mis_q;
  assign FETCH_CNT = cnt_q;
endmodule

// File: tb/tb_otter_fetch_stage.sv
// tb_otter_fetch_stage: directed scoreboard bench for otter_fetch_stage with a sync-read, hold-on-disable memory model
module tb_otter_fetch_stage;
  logic        CLK = 1'b0, RST = 1'b1, STALL = 1'b0, BR_TAKEN = 1'b0, MEM_RDEN1, IF_VALID, IF_FAULT, MISALIGN;
  logic [31:0] BR_TARGET = '0, MEM_DOUT1 = '0, IF_PC, IF_PC4, IF_INSTR, FETCH_CNT;
  logic [13:0] MEM_ADDR1;
  int n_vec = 0, n_err = 0;
  typedef struct {logic rden, vld, flt, mis; logic [31:0] pc, cnt;} exp_t;
  exp_t sbq[$];
  otter_fetch_stage dut (
    .CLK(CLK), .RST(RST), .STALL(STALL), .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
    .MEM_DOUT1(MEM_DOUT1), .MEM_RDEN1(MEM_RDEN1), .MEM_ADDR1(MEM_ADDR1), .IF_PC(IF_PC),
    .IF_PC4(IF_PC4), .IF_INSTR(IF_INSTR), .IF_VALID(IF_VALID), .IF_FAULT(IF_FAULT),
    .MISALIGN(MISALIGN), .FETCH_CNT(FETCH_CNT)
  );
  always #5 CLK = ~CLK;
  function automatic logic [31:0] memw(input logic [31:0] pc);
    return 32'hA000_0000 | {18'd0, pc[15:2]};
  endfunction
  always @(posedge CLK) if (MEM_RDEN1) MEM_DOUT1 <= 32'hA000_0000 | {18'd0, MEM_ADDR1};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got %h expected %h", name, $time, act, exp);
    end
  endtask
  task automatic chk_all(input exp_t e);
    chk("rden", {31'd0, MEM_RDEN1}, {31'd0, e.rden});
    chk("valid", {31'd0, IF_VALID}, {31'd0, e.vld});
    chk("pc", IF_PC, e.pc);
    chk("pc4", IF_PC4, e.pc + 32'd4);
    chk("instr", IF_INSTR, e.vld ? memw(e.pc) : 32'h0000_0013);
    chk("fault", {31'd0, IF_FAULT}, {31'd0, e.flt});
    chk("misalign", {31'd0, MISALIGN}, {31'd0, e.mis});
    chk("fetch_cnt", FETCH_CNT, e.cnt);
  endtask
  always @(negedge CLK) if (sbq.size() > 0) chk_all(sbq.pop_front());
  task automatic cyc(input logic st, input logic br, input logic [31:0] tgt, input logic vld,
                     input logic [31:0] pc, input logic flt, input logic mis, input logic [31:0] cnt);
    @(posedge CLK);
    #1;
    RST = 1'b0;
    STALL = st;
    BR_TAKEN = br;
    BR_TARGET = tgt;
    sbq.push_back('{rden: ~st, vld: vld, flt: flt, mis: mis, pc: pc, cnt: cnt});
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end
  initial begin
    repeat (2) @(negedge CLK);
    chk_all('{rden: 1'b1, vld: 1'b0, flt: 1'b0, mis: 1'b0, pc: 32'h0, cnt: 32'h0});
    cyc(0, 0, 0,          0, 32'h000, 0, 0, 0);
    cyc(0, 0, 0,          1, 32'h000, 0, 0, 0);
    cyc(0, 0, 0,          1, 32'h004, 0, 0, 1);
    cyc(1, 0, 0,          1, 32'h008, 0, 0, 2);
    cyc(1, 0, 0,          1, 32'h008, 0, 0, 2);
    cyc(1, 0, 0,          1, 32'h008, 0, 0, 2);
    cyc(0, 0, 0,          1, 32'h008, 0, 0, 2);
    cyc(0, 1, 32'h100,    1, 32'h00C, 0, 0, 3);
    cyc(0, 0, 0,          0, 32'h010, 0, 0, 3);
    cyc(0, 0, 0,          1, 32'h100, 0, 0, 3);
    cyc(0, 0, 0,          1, 32'h104, 0, 0, 4);
    cyc(1, 1, 32'h40,     1, 32'h108, 0, 0, 5);
    cyc(1, 0, 0,          0, 32'h10C, 0, 0, 5);
    cyc(0, 0, 0,          0, 32'h10C, 0, 0, 5);
    cyc(0, 0, 0,          1, 32'h040, 0, 0, 5);
    cyc(0, 1, 32'h202,    1, 32'h044, 0, 0, 6);
    cyc(0, 0, 0,          0, 32'h048, 0, 1, 6);
    cyc(0, 0, 0,          1, 32'h200, 0, 1, 6);
    cyc(0, 1, 32'h4000,   1, 32'h204, 0, 1, 7);
    cyc(0, 0, 0,          0, 32'h208, 0, 1, 7);
    cyc(0, 0, 0,          1, 32'h4000, 1, 1, 7);
    cyc(0, 0, 0,          1, 32'h4004, 1, 1, 8);
    @(negedge CLK);
    #2;
    RST = 1'b1;
    #1;
    chk("rst_valid", {31'd0, IF_VALID}, 32'd0);
    chk("rst_cnt", FETCH_CNT, 32'd0);
    chk("rst_pc", IF_PC, 32'd0);
    chk("rst_misalign", {31'd0, MISALIGN}, 32'd0);
    chk("rst_instr", IF_INSTR, 32'h0000_0013);
    cyc(0, 0, 0,            0, 32'h000, 0, 0, 0);
    cyc(0, 0, 0,            1, 32'h000, 0, 0, 0);
    cyc(0, 0, 0,            1, 32'h004, 0, 0, 1);
    cyc(0, 1, 32'hFFFF_FFFC, 1, 32'h008, 0, 0, 2);
    cyc(0, 0, 0,            0, 32'h00C, 0, 0, 2);
    cyc(0, 0, 0,            1, 32'hFFFF_FFFC, 1, 0, 2);
    cyc(0, 0, 0,            1, 32'h000, 0, 0, 3);
    @(negedge CLK);
    #1;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain left %0d expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
